// File: rtl/ram_frame_reader.sv
// ram_frame_reader
//   Read-side consumer for the ping-pong sample buffer. After a frame-ready
//   pulse it drains exactly DEPTH samples over the buffer's ready/valid read
//   port and re-emits them on a registered downstream stream tagged with
//   first/last markers. It also counts completed frames and flags overruns.
//
//   Optional feature macro: RAM_FRAME_READER_SUM_EN
//     defined   -> signed per-frame sum on frame_sum_o / frame_sum_valid_o
//     undefined -> frame_sum_o and frame_sum_valid_o are tied to 0
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   buf_frame_start_i   1-cycle pulse: a full buffer is ready
//   buf_data_i          signed sample from the buffer read port
//   buf_valid_i         buffer read data valid
//   buf_ready_o         reader accepts a sample this cycle (combinational)
//   m_data_o            signed output sample (head of 2-entry queue)
//   m_valid_o           output valid (queue non-empty)
//   m_ready_i           downstream ready
//   m_first_o/m_last_o  sample index 0 / DEPTH-1 of a frame
//   busy_o              FSM is draining a frame
//   frame_count_o       completed frames, wraps silently
//   overrun_o           1-cycle pulse: frame start arrived while draining
//   frame_sum_o         signed frame sum (feature build only)
//   frame_sum_valid_o   1-cycle pulse qualifying frame_sum_o
module ram_frame_reader #(
   parameter int WIDTH      = 32,
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int FCNT_WIDTH = 16
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               buf_frame_start_i,
   input  logic signed [WIDTH-1:0]            buf_data_i,
   input  logic                               buf_valid_i,
   output logic                               buf_ready_o,
   output logic signed [WIDTH-1:0]            m_data_o,
   output logic                               m_valid_o,
   input  logic                               m_ready_i,
   output logic                               m_first_o,
   output logic                               m_last_o,
   output logic                               busy_o,
   output logic [FCNT_WIDTH-1:0]              frame_count_o,
   output logic                               overrun_o,
   output logic signed [WIDTH+ADDR_WIDTH:0]   frame_sum_o,
   output logic                               frame_sum_valid_o
);

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [ADDR_WIDTH-1:0]   r_idx;
   logic [ADDR_WIDTH-1:0]   w_idx_nxt;
   logic                    w_tag_first;
   logic                    w_tag_last;
   logic                    w_frame_done;
   logic                    w_overrun;
   logic                    w_acc_in;
   logic                    w_acc_out;

   // Queue storage: slot 0 is the head and drives the m_* outputs directly.
   logic signed [WIDTH-1:0] r_q_data [2];
   logic [1:0]              r_q_first;
   logic [1:0]              r_q_last;
   logic [1:0]              r_q_count;
   logic [FCNT_WIDTH-1:0]   r_frame_count;
   logic                    r_overrun;

   assign buf_ready_o   = (r_state == ST_DRAIN) && (r_q_count < 2'd2);
   assign w_acc_in      = buf_valid_i & buf_ready_o;
   assign m_valid_o     = (r_q_count != 2'd0);
   assign w_acc_out     = m_valid_o & m_ready_i;
   assign m_data_o      = r_q_data[0];
   assign m_first_o     = r_q_first[0];
   assign m_last_o      = r_q_last[0];
   assign busy_o        = (r_state == ST_DRAIN);
   assign frame_count_o = r_frame_count;
   assign overrun_o     = r_overrun;

   // FSM state and sample index registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   // FSM next state, sample tagging, frame completion and overrun detection
   always_comb begin
      w_state_nxt  = r_state;
      w_idx_nxt    = r_idx;
      w_tag_first  = (r_idx == '0);
      w_tag_last   = 1'b0;
      w_frame_done = 1'b0;
      w_overrun    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (buf_frame_start_i) begin
               w_state_nxt = ST_DRAIN;
               w_idx_nxt   = '0;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (w_acc_in) begin
               if (r_idx == LAST_IDX) begin
                  w_tag_last   = 1'b1;
                  w_frame_done = 1'b1;
                  w_idx_nxt    = '0;
                  w_state_nxt  = ST_IDLE;
               end else begin
                  w_idx_nxt = r_idx + ADDR_WIDTH'(1);
               end
            end else begin
               w_idx_nxt = r_idx;
            end
            // A start that coincides with the last sample chains the next
            // frame; any other start while draining aborts the current one.
            if (buf_frame_start_i) begin
               w_state_nxt = ST_DRAIN;
               w_idx_nxt   = '0;
               w_overrun   = ~w_frame_done;
            end else begin
               w_overrun = 1'b0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
         end
      endcase
   end

   // Two-entry output queue; push and pop at count 1 keeps the count at 1
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_q_data[0] <= '0;
         r_q_data[1] <= '0;
         r_q_first   <= 2'b00;
         r_q_last    <= 2'b00;
         r_q_count   <= 2'd0;
      end else begin
         case ({w_acc_in, w_acc_out})
            2'b10: begin
               if (r_q_count == 2'd0) begin
                  r_q_data[0]  <= buf_data_i;
                  r_q_first[0] <= w_tag_first;
                  r_q_last[0]  <= w_tag_last;
               end else begin
                  r_q_data[1]  <= buf_data_i;
                  r_q_first[1] <= w_tag_first;
                  r_q_last[1]  <= w_tag_last;
               end
               r_q_count <= r_q_count + 2'd1;
            end
            2'b01: begin
               r_q_data[0]  <= r_q_data[1];
               r_q_first[0] <= r_q_first[1];
               r_q_last[0]  <= r_q_last[1];
               r_q_count    <= r_q_count - 2'd1;
            end
            2'b11: begin
               if (r_q_count == 2'd1) begin
                  r_q_data[0]  <= buf_data_i;
                  r_q_first[0] <= w_tag_first;
                  r_q_last[0]  <= w_tag_last;
               end else begin
                  r_q_data[0]  <= r_q_data[1];
                  r_q_first[0] <= r_q_first[1];
                  r_q_last[0]  <= r_q_last[1];
                  r_q_data[1]  <= buf_data_i;
                  r_q_first[1] <= w_tag_first;
                  r_q_last[1]  <= w_tag_last;
               end
            end
            default: begin
               r_q_count <= r_q_count;
            end
         endcase
      end
   end

   // Frame counter and overrun pulse
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_frame_count <= '0;
         r_overrun     <= 1'b0;
      end else begin
         if (w_frame_done) begin
            r_frame_count <= r_frame_count + FCNT_WIDTH'(1);
         end else begin
            r_frame_count <= r_frame_count;
         end
         r_overrun <= w_overrun;
      end
   end

`ifdef RAM_FRAME_READER_SUM_EN
   localparam int SW = WIDTH + ADDR_WIDTH + 1;

   logic signed [SW-1:0] r_acc;
   logic signed [SW-1:0] w_sample_ext;
   logic signed [SW-1:0] w_sum_nxt;
   logic signed [SW-1:0] r_sum;
   logic                 r_sum_valid;

   assign w_sample_ext      = {{(SW - WIDTH){buf_data_i[WIDTH-1]}}, buf_data_i};
   assign w_sum_nxt         = w_tag_first ? w_sample_ext : (r_acc + w_sample_ext);
   assign frame_sum_o       = r_sum;
   assign frame_sum_valid_o = r_sum_valid;

   // Frame accumulator; the result is published only for completed frames
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_acc       <= '0;
         r_sum       <= '0;
         r_sum_valid <= 1'b0;
      end else begin
         if (w_acc_in && (r_state == ST_DRAIN)) begin
            r_acc <= w_sum_nxt;
         end else begin
            r_acc <= r_acc;
         end
         if (w_tag_last) begin
            r_sum <= w_sum_nxt;
         end else begin
            r_sum <= r_sum;
         end
         r_sum_valid <= w_tag_last;
      end
   end
`else
   assign frame_sum_o       = '0;
   assign frame_sum_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_ram_frame_reader.sv
module tb_ram_frame_reader;
   localparam int D  = 4;
   localparam int FW = 16;

   logic               clk = 1'b0;
   logic               rst_i = 1'b1;
   logic               buf_frame_start_i = 1'b0;
   logic signed [31:0] buf_data_i = '0;
   logic               buf_valid_i = 1'b0;
   logic               m_ready_i = 1'b0;
   logic               buf_ready_o;
   logic signed [31:0] m_data_o;
   logic               m_valid_o;
   logic               m_first_o;
   logic               m_last_o;
   logic               busy_o;
   logic [FW-1:0]      frame_count_o;
   logic               overrun_o;
   logic signed [34:0] frame_sum_o;
   logic               frame_sum_valid_o;

   always #5 clk = ~clk;

   ram_frame_reader #(.WIDTH(32), .DEPTH(D), .FCNT_WIDTH(FW)) dut (
      .clk_i(clk), .rst_i(rst_i), .buf_frame_start_i(buf_frame_start_i),
      .buf_data_i(buf_data_i), .buf_valid_i(buf_valid_i), .buf_ready_o(buf_ready_o),
      .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
      .m_first_o(m_first_o), .m_last_o(m_last_o), .busy_o(busy_o),
      .frame_count_o(frame_count_o), .overrun_o(overrun_o),
      .frame_sum_o(frame_sum_o), .frame_sum_valid_o(frame_sum_valid_o)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model (frame-level view) ----------------
   typedef struct {
      logic signed [31:0] d;
      bit                 f;
      bit                 l;
   } item_t;

   item_t       mq[$];      // samples accepted but not yet taken downstream
   bit          m_in_frame = 1'b0;
   int          m_pos = 0;
   logic [15:0] m_fc = '0;
   bit          m_ovr = 1'b0;
   longint      m_acc = 0;
   longint      m_sum = 0;
   bit          m_sum_v = 1'b0;
   bit          last_acc = 1'b0;

   task automatic model_reset();
      mq.delete();
      m_in_frame = 1'b0; m_pos = 0; m_fc = '0; m_ovr = 1'b0;
      m_acc = 0; m_sum = 0; m_sum_v = 1'b0;
   endtask

   // One clock cycle: compare at negedge, advance the model, return after posedge.
   task automatic tick();
      bit exp_valid, exp_ready, a_in, a_out, was_in, is_last;
      @(negedge clk);
      exp_valid = (mq.size() > 0);
      exp_ready = m_in_frame && (mq.size() < 2);
      chk("m_valid", m_valid_o, exp_valid);
      if (exp_valid) begin
         chk("m_data",  m_data_o,  mq[0].d);
         chk("m_first", m_first_o, mq[0].f);
         chk("m_last",  m_last_o,  mq[0].l);
      end
      chk("buf_ready", buf_ready_o, exp_ready);
      chk("busy", busy_o, m_in_frame);
      chk("frame_count", frame_count_o, m_fc);
      chk("overrun", overrun_o, m_ovr);
`ifdef RAM_FRAME_READER_SUM_EN
      chk("sum_valid", frame_sum_valid_o, m_sum_v);
      chk("frame_sum", {{29{frame_sum_o[34]}}, frame_sum_o}, m_sum);
`else
      chk("sum_valid_tied", frame_sum_valid_o, 1'b0);
      chk("frame_sum_tied", frame_sum_o, 35'd0);
`endif
      a_in  = buf_valid_i && exp_ready;
      a_out = exp_valid && m_ready_i;
      last_acc = a_in && !rst_i;
      if (rst_i) begin
         model_reset();
      end else begin
         was_in  = m_in_frame;
         is_last = a_in && (m_pos == D - 1);
         m_ovr   = 1'b0;
         m_sum_v = 1'b0;
         if (a_out) void'(mq.pop_front());
         if (a_in) begin
            mq.push_back('{d: buf_data_i, f: (m_pos == 0), l: is_last});
            m_acc = (m_pos == 0) ? longint'(buf_data_i) : m_acc + longint'(buf_data_i);
            if (is_last) begin
               m_sum = m_acc; m_sum_v = 1'b1; m_fc++;
               m_in_frame = 1'b0; m_pos = 0;
            end else begin
               m_pos++;
            end
         end
         if (buf_frame_start_i) begin
            if (was_in && !is_last) m_ovr = 1'b1;
            m_in_frame = 1'b1; m_pos = 0;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic drive(input bit st, input bit v, input logic signed [31:0] d, input bit mr);
      buf_frame_start_i = st; buf_valid_i = v; buf_data_i = d; m_ready_i = mr;
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'sd0, 1'b1);
   endtask

   // Present n samples base, base+1, ... until all are accepted (bounded).
   task automatic feed(input int n, input int base);
      int k = 0;
      int budget = 0;
      while (k < n && budget < 60) begin
         drive(1'b0, 1'b1, 32'(base + k), 1'b1);
         if (last_acc) k++;
         budget++;
      end
      if (k < n) chk("feed_timeout", 64'(k), 64'(n));
   endtask

   task automatic rst_chk(input string tag);
      chk({tag, "_m_valid"}, m_valid_o, 1'b0);
      chk({tag, "_m_data"}, m_data_o, 32'd0);
      chk({tag, "_m_first"}, m_first_o, 1'b0);
      chk({tag, "_m_last"}, m_last_o, 1'b0);
      chk({tag, "_buf_ready"}, buf_ready_o, 1'b0);
      chk({tag, "_busy"}, busy_o, 1'b0);
      chk({tag, "_fcount"}, frame_count_o, 16'd0);
      chk({tag, "_overrun"}, overrun_o, 1'b0);
      chk({tag, "_sum"}, frame_sum_o, 35'd0);
      chk({tag, "_sum_valid"}, frame_sum_valid_o, 1'b0);
   endtask

   typedef struct {
      bit                 st;
      bit                 v;
      logic signed [31:0] d;
      bit                 mr;
      bit                 e_valid;
      logic signed [31:0] e_data;
      bit                 e_first;
      bit                 e_last;
      bit                 e_ready;
      bit                 e_busy;
      logic [15:0]        e_fc;
   } vec_t;

   vec_t vt[7];

   initial begin
      logic [15:0]        fc0;
      logic signed [31:0] sd[4];
      // Basic frame 10,-3,7,1; expectations are the outputs seen in that cycle.
      vt[0] = '{1'b1, 1'b0, 32'sd0,  1'b1, 1'b0, 32'sd0,  1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
      vt[1] = '{1'b0, 1'b1, 32'sd10, 1'b1, 1'b0, 32'sd0,  1'b0, 1'b0, 1'b1, 1'b1, 16'd0};
      vt[2] = '{1'b0, 1'b1, -32'sd3, 1'b1, 1'b1, 32'sd10, 1'b1, 1'b0, 1'b1, 1'b1, 16'd0};
      vt[3] = '{1'b0, 1'b1, 32'sd7,  1'b1, 1'b1, -32'sd3, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0};
      vt[4] = '{1'b0, 1'b1, 32'sd1,  1'b1, 1'b1, 32'sd7,  1'b0, 1'b0, 1'b1, 1'b1, 16'd0};
      vt[5] = '{1'b0, 1'b0, 32'sd0,  1'b1, 1'b1, 32'sd1,  1'b0, 1'b1, 1'b0, 1'b0, 16'd1};
      vt[6] = '{1'b0, 1'b0, 32'sd0,  1'b1, 1'b0, 32'sd0,  1'b0, 1'b0, 1'b0, 1'b0, 16'd1};

      repeat (3) @(posedge clk);
      #1;
      rst_i = 1'b0;
      rst_chk("reset");

      // 1. Basic frame (table)
      for (int i = 0; i < 7; i++) begin
         buf_frame_start_i = vt[i].st; buf_valid_i = vt[i].v;
         buf_data_i = vt[i].d; m_ready_i = vt[i].mr;
         #1;
         chk($sformatf("vec%0d_valid", i), m_valid_o, vt[i].e_valid);
         if (vt[i].e_valid) begin
            chk($sformatf("vec%0d_data", i), m_data_o, vt[i].e_data);
            chk($sformatf("vec%0d_first", i), m_first_o, vt[i].e_first);
            chk($sformatf("vec%0d_last", i), m_last_o, vt[i].e_last);
         end
         chk($sformatf("vec%0d_ready", i), buf_ready_o, vt[i].e_ready);
         chk($sformatf("vec%0d_busy", i), busy_o, vt[i].e_busy);
         chk($sformatf("vec%0d_fc", i), frame_count_o, vt[i].e_fc);
         tick();
      end

      // 2. Backpressure: downstream stalls 5 cycles mid-frame
      drive(1'b1, 1'b0, 32'sd0, 1'b1);
      drive(1'b0, 1'b1, 32'sd100, 1'b1);
      drive(1'b0, 1'b1, 32'sd101, 1'b1);
      for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 32'sd102 + 32'(i > 0 ? 1 : 0), 1'b0);
      chk("bp_ready_low", buf_ready_o, 1'b0);
      feed(1, 103);
      idle(4);

      // 3. Overrun: abort after 2 samples, then a full frame
      fc0 = m_fc;
      drive(1'b1, 1'b0, 32'sd0, 1'b1);
      feed(2, 200);
      drive(1'b1, 1'b0, 32'sd0, 1'b1);
      chk("ovr_pulse", overrun_o, 1'b1);
      feed(4, 300);
      idle(4);
      chk("ovr_fcount", frame_count_o, fc0 + 16'd1);

      // 4. Back-to-back: start coincides with the last sample's acceptance
      fc0 = m_fc;
      drive(1'b1, 1'b0, 32'sd0, 1'b1);
      feed(3, 400);
      drive(1'b1, 1'b1, 32'sd403, 1'b1);
      chk("b2b_no_ovr", overrun_o, 1'b0);
      chk("b2b_busy", busy_o, 1'b1);
      feed(4, 500);
      idle(4);
      chk("b2b_fcount", frame_count_o, fc0 + 16'd2);

      // 5. Reset mid-frame
      drive(1'b1, 1'b0, 32'sd0, 1'b1);
      feed(2, 600);
      rst_i = 1'b1;
      drive(1'b0, 1'b0, 32'sd0, 1'b0);
      rst_i = 1'b0;
      rst_chk("midrst");
      drive(1'b1, 1'b0, 32'sd0, 1'b1);
      feed(4, 700);
      idle(4);
      chk("midrst_fcount", frame_count_o, 16'd1);

      // 6. Frame sum, plus an aborted frame that must not publish a sum
      sd[0] = 32'sh8000_0000; sd[1] = -32'sd1; sd[2] = 32'sd5; sd[3] = 32'sd0;
      drive(1'b1, 1'b0, 32'sd0, 1'b1);
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, sd[i], 1'b1);
      idle(3);
`ifdef RAM_FRAME_READER_SUM_EN
      chk("sum_value", {{29{frame_sum_o[34]}}, frame_sum_o}, -64'sd2147483644);
`else
      chk("sum_tied", frame_sum_o, 35'd0);
`endif
      drive(1'b1, 1'b0, 32'sd0, 1'b1);
      feed(2, 800);
      drive(1'b1, 1'b0, 32'sd0, 1'b1);
      feed(4, 900);
      idle(4);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         rst_i = ($urandom_range(0, 499) == 0);
         drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
               $signed($urandom), ($urandom_range(0, 2) != 0));
      end
      rst_i = 1'b0;
      idle(6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
